// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing one dual-port RAM: owns pointers, occupancy, flags and sticky errors.
// Latency: push lands in RAM at the next edge; popped word appears on rd_data one cycle after pop.
// Backpressure: push is refused while full (sets overflow), pop is refused while empty (sets underflow).
module ram_fifo_ctrl #(
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDER_SIZE = 10,
    parameter int AFULL_TH   = 1020,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [MEM_WIDTH-1:0]  push_data,
    input  logic                  pop,
    input  logic                  err_clr,
    output logic [MEM_WIDTH-1:0]  ram_din,
    output logic [ADDER_SIZE-1:0] ram_addr_wr,
    output logic [ADDER_SIZE-1:0] ram_addr_rd,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    output logic                  ram_blk_select,
    input  logic [MEM_WIDTH-1:0]  ram_dout,
    output logic [MEM_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic [ADDER_SIZE:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDER_SIZE:0]   DEPTH_C  = (ADDER_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDER_SIZE:0]   AFULL_C  = (ADDER_SIZE+1)'(AFULL_TH);
    localparam logic [ADDER_SIZE:0]   AEMPTY_C = (ADDER_SIZE+1)'(AEMPTY_TH);
    localparam logic [ADDER_SIZE:0]   CNT_ONE  = (ADDER_SIZE+1)'(1);
    localparam logic [ADDER_SIZE-1:0] PTR_ONE  = ADDER_SIZE'(1);

    logic [ADDER_SIZE-1:0] wr_ptr;
    logic [ADDER_SIZE-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Status flags decode straight from the registered occupancy so they never glitch on requests.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // Requests are qualified against start-of-cycle flags; refused ones never touch the RAM.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // RAM is driven combinationally in the request cycle; it registers the read internally.
    assign ram_din        = push_data;
    assign ram_addr_wr    = wr_ptr;
    assign ram_addr_rd    = rd_ptr;
    assign ram_wr_en      = push_ok;
    assign ram_rd_en      = pop_ok;
    assign ram_blk_select = push_ok | pop_ok;
    assign rd_data        = ram_dout;

    // Pointers advance on accepted requests and wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Occupancy: a simultaneous accepted push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // rd_valid tracks the RAM's one-cycle registered read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
        end
    end

    // Sticky errors: a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full)  overflow  <= 1'b1;
            else if (err_clr)  overflow  <= 1'b0;
            if (pop && empty)  underflow <= 1'b1;
            else if (err_clr)  underflow <= 1'b0;
        end
    end

endmodule
